// File: rtl/xtea.sv
// XTEA engine: two 64-bit blocks in parallel, one full cycle per clock.
// start/ready handshake, 32 cycles per encrypt or decrypt operation.
module xtea #(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         enc_dec,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         busy,
  output logic         ready,
  output logic [127:0] data_out
);

  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [31:0] SUM_DEC = DELTA * 32'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [31:0]   sum_q;
  logic [31:0]   sum_nx;
  logic [127:0]  key_q;
  logic          enc_q;
  logic [127:0]  blk_q;
  logic [127:0]  dout_q;
  logic [127:0]  rnd;
  logic          last;

  function automatic logic [31:0] mix(
    input logic [31:0] v
  );
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction

  function automatic logic [31:0] ksel(
    input logic [127:0] k,
    input logic [1:0]   i
  );
    logic [31:0] r;
    unique case (i)
      2'd0:    r = k[127:96];
      2'd1:    r = k[95:64];
      2'd2:    r = k[63:32];
      default: r = k[31:0];
    endcase
    return r;
  endfunction

  // One full XTEA cycle on a {v0, v1} block.
  function automatic logic [63:0] xround(
    input logic         enc,
    input logic [63:0]  blk,
    input logic [31:0]  sum,
    input logic [127:0] k
  );
    logic [31:0] v0, v1, s1;
    v0 = blk[63:32];
    v1 = blk[31:0];
    if (enc) begin
      s1 = sum + DELTA;
      v0 = v0 + (mix(v1) ^ (sum + ksel(k, sum[1:0])));
      v1 = v1 + (mix(v0) ^ (s1 + ksel(k, s1[12:11])));
    end else begin
      s1 = sum - DELTA;
      v1 = v1 - (mix(v0) ^ (sum + ksel(k, sum[12:11])));
      v0 = v0 - (mix(v1) ^ (s1 + ksel(k, s1[1:0])));
    end
    return {v0, v1};
  endfunction

  assign rnd = {
    xround(enc_q, blk_q[127:64], sum_q, key_q),
    xround(enc_q, blk_q[63:0], sum_q, key_q)
  };

  assign sum_nx = enc_q ? (sum_q + DELTA)
                        : (sum_q - DELTA);

  assign last = (cnt_q == CW'(ROUNDS - 1));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      key_q   <= '0;
      enc_q   <= 1'b0;
      blk_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            blk_q <= data_in;
            key_q <= key;
            enc_q <= enc_dec;
            cnt_q <= '0;
            sum_q <= enc_dec ? 32'h0 : SUM_DEC;
          end
        end
        RUN: begin
          blk_q <= rnd;
          sum_q <= sum_nx;
          cnt_q <= cnt_q + CW'(1);
          if (last) dout_q <= rnd;
        end
        default: ;
      endcase
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_xtea.sv
// Scoreboard bench for xtea: stimulus pushes expected results,
// a negedge monitor pops and compares on every ready pulse.
module tb_xtea;

  logic         clock;
  logic         reset;
  logic         start;
  logic         enc_dec;
  logic [127:0] data_in;
  logic [127:0] key;
  logic         busy;
  logic         ready;
  logic [127:0] data_out;

  int checks   = 0;
  int failures = 0;
  int ready_cnt = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_out = '0;

  localparam logic [127:0] K1  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PT1 = 128'h41424344454647484142434445464748;
  localparam logic [127:0] CT1 = 128'h497DF3D072612CB5497DF3D072612CB5;
  localparam logic [127:0] K2  = 128'hDEADBEEF89ABCDEF01234567DEADBEEF;
  localparam logic [127:0] PT2 = 128'h4D932AB3CE76E4F22555F334089975E9;

  xtea dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .enc_dec  (enc_dec),
    .data_in  (data_in),
    .key      (key),
    .busy     (busy),
    .ready    (ready),
    .data_out (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Textbook XTEA on one 64-bit block.
  function automatic logic [63:0] ref64(
    input logic         enc,
    input logic [127:0] k,
    input logic [63:0]  blk
  );
    logic [31:0] v0, v1, sum;
    logic [31:0] kk[4];
    kk[0] = k[127:96];
    kk[1] = k[95:64];
    kk[2] = k[63:32];
    kk[3] = k[31:0];
    v0 = blk[63:32];
    v1 = blk[31:0];
    if (enc) begin
      sum = 32'h0;
      for (int i = 0; i < 32; i++) begin
        v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kk[sum & 3]);
        sum += 32'h9E3779B9;
        v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kk[(sum >> 11) & 3]);
      end
    end else begin
      sum = 32'hC6EF3720;
      for (int i = 0; i < 32; i++) begin
        v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kk[(sum >> 11) & 3]);
        sum -= 32'h9E3779B9;
        v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kk[sum & 3]);
      end
    end
    return {v0, v1};
  endfunction

  function automatic logic [127:0] ref128(
    input logic         enc,
    input logic [127:0] k,
    input logic [127:0] d
  );
    return {ref64(enc, k, d[127:64]), ref64(enc, k, d[63:0])};
  endfunction

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && ready) begin
      logic [127:0] e;
      ready_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready got=%h exp=none", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL result got=%h exp=%h", data_out, e);
        end
      end
      last_out = data_out;
    end
  end

  task automatic issue(input logic enc, input logic [127:0] k,
                       input logic [127:0] d, input logic [127:0] exp);
    enc_dec = enc;
    key     = k;
    data_in = d;
    start   = 1'b1;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcyc);
    lat  = -1;
    bcyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy) bcyc++;
      if (ready) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout got=no_ready exp=ready");
      exp_q.delete();
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int lat, bcyc, rc0;
    logic [127:0] cur, m, e, d;

    reset   = 1'b1;
    start   = 1'b1;
    enc_dec = 1'b1;
    key     = K1;
    data_in = PT1;
    repeat (2) @(posedge clock);
    #1;
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_ready", 128'(ready), 128'(0));
    chk("reset_dout", data_out, 128'h0);
    @(posedge clock);
    #1;

    issue(1'b1, K1, PT1, CT1);
    wait_done(lat, bcyc);
    chk("kat_enc_latency", 128'(lat), 128'(32));
    chk("kat_enc_busy", 128'(bcyc), 128'(32));

    issue(1'b0, K1, CT1, PT1);
    wait_done(lat, bcyc);
    chk("kat_dec_latency", 128'(lat), 128'(32));
    chk("kat_dec_busy", 128'(bcyc), 128'(32));

    cur = PT2;
    m   = PT2;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        m = ref128(1'b1, K2, m);
        e = m;
      end else begin
        m = ref128(1'b0, K2, m);
        e = PT2;
      end
      issue(i % 2 == 0, K2, cur, e);
      wait_done(lat, bcyc);
      cur = last_out;
      if (i % 2 == 1) chk("chain_plain", last_out, PT2);
    end

    d = {PT1[127:64], 64'h0123456789ABCDEF};
    issue(1'b1, K1, d, {CT1[127:64], ref64(1'b1, K1, d[63:0])});
    wait_done(lat, bcyc);
    chk("half_indep", {64'h0, last_out[127:64]}, {64'h0, CT1[127:64]});

    rc0 = ready_cnt;
    issue(1'b1, K1, PT1, CT1);
    chk("dout_hold_on_start", data_out, last_out);
    repeat (5) @(posedge clock);
    #1;
    enc_dec = 1'b0;
    key     = K2;
    data_in = PT2;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start   = 1'b0;
    wait_done(lat, bcyc);
    repeat (5) @(posedge clock);
    #1;
    chk("single_ready", 128'(ready_cnt - rc0), 128'(1));

    issue(1'b1, K1, PT1, CT1);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_ready", 128'(ready), 128'(0));
    chk("abort_dout", data_out, 128'h0);

    issue(1'b1, K1, PT1, CT1);
    wait_done(lat, bcyc);
    chk("post_abort_latency", 128'(lat), 128'(32));

    repeat (3) @(posedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xtea.md
Name: xtea

Overview:
- XTEA block-cipher engine: encrypts or decrypts 128 bits per operation with a 128-bit key.
- The 128 bits are two independent 64-bit XTEA blocks (ECB, same key).
- Iterative: one full XTEA cycle (two Feistel half-rounds) per clock, 32 cycles per operation.
- Sits as a memory-mapped or streaming crypto accelerator behind a simple start/ready handshake.

Parameters:
- ROUNDS, 32, number of XTEA cycles per operation.
- DELTA, 32'h9E3779B9, key-schedule constant.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only when idle.
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled with start.
- data_in  in  128  block A = [127:64] (v0=[127:96], v1=[95:64]); block B = [63:0] (v0=[63:32], v1=[31:0]).
- key  in  128  k[0]=[127:96], k[1]=[95:64], k[2]=[63:32], k[3]=[31:0]; sampled with start.
- busy  out  1  high while rounds are in progress.
- ready  out  1  one-cycle pulse; data_out is valid from this cycle on.
- data_out  out  128  result, same packing as data_in.

Behaviour:
- One clock (clock); reset is synchronous and active-high. On reset: state IDLE; busy=0, ready=0, data_out=0; round counter=0.
- States: IDLE, RUN, DONE.
- IDLE + start=1 at edge E0: latch data_in, key and enc_dec into internal registers; counter=0; go to RUN.
  - On entering RUN, sum=0 for encrypt and sum=32'hC6EF3720 (DELTA*32 mod 2^32) for decrypt.
- IDLE with start=0: nothing changes; data_out holds.
- RUN, each edge: apply one XTEA cycle to both blocks in parallel, then counter+1. After the 32nd cycle (edge E32), go to DONE. All arithmetic is mod 2^32; shifts are logical.
  - Encrypt:
    - v0 += (((v1<<4)^(v1>>5))+v1) ^ (sum + k[sum&3])
    - sum += DELTA
    - v1 += (((v0<<4)^(v0>>5))+v0) ^ (sum + k[(sum>>11)&3]), using the updated v0 and sum.
  - Decrypt:
    - v1 -= (((v0<<4)^(v0>>5))+v0) ^ (sum + k[(sum>>11)&3])
    - sum -= DELTA
    - v0 -= (((v1<<4)^(v1>>5))+v1) ^ (sum + k[sum&3]), using the updated v1 and sum.
- busy=1 from the edge after E0 through the cycle preceding DONE; busy=0 in IDLE and DONE.
- DONE (one cycle):
  - ready=1 and data_out = final {A.v0, A.v1, B.v0, B.v1}; return to IDLE on the next edge.
  - Latency: ready is high in the 33rd cycle after the start edge.
- data_out holds its value until the next operation completes; it is not cleared by start.
- ready is 0 in all states except DONE.
- start while in RUN or DONE is ignored. No queuing.
- Changes to data_in, key or enc_dec after the start edge do not affect the running operation.
- Reset asserted mid-operation aborts immediately: IDLE, busy=0, ready=0, data_out=0.
- start and reset in the same cycle: reset wins.
- Back-to-back operation: a start applied in the first IDLE cycle after ready is accepted normally.

Test Plan:
- Reset: hold reset 2 cycles -> busy=0, ready=0, data_out=0; start while reset=1 is ignored.
- Known-answer encrypt:
  - Stimulus: key=128'h000102030405060708090A0B0C0D0E0F, data_in=128'h41424344454647484142434445464748, enc_dec=1, start pulse.
  - Response: busy high 32 cycles; single ready pulse; data_out=128'h497DF3D072612CB5497DF3D072612CB5.
- Known-answer decrypt: same key, data_in=128'h497DF3D072612CB5497DF3D072612CB5, enc_dec=0 -> data_out=128'h41424344454647484142434445464748.
- Round-trip chain:
  - Setup: key=128'hDEADBEEF89ABCDEF01234567DEADBEEF, data_in=128'h4D932AB3CE76E4F22555F334089975E9.
  - Run 8 operations alternating enc/dec, feeding data_out back as data_in.
  - Response: after every decrypt, data_out equals the original plaintext. Block halves are independent: changing only [63:0] leaves [127:64] of the result unchanged.
- Busy protection: pulse start again mid-RUN with different data -> ignored; result matches the first request; exactly one ready pulse.
- Reset mid-operation: assert reset at round 10 -> next cycle busy=0, ready=0, data_out=0. A new start afterwards produces the correct known-answer result.
